pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL provide: clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_i  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide: start_i  input  1  CPU run enable; 0 freezes PC and IF/ID.
REQ-004 SHALL provide: PCWrite_i  input  1  PC update permit from hazard detection.
REQ-005 SHALL provide: Stall_i  input  1  IF/ID hold request from hazard detection.
REQ-006 SHALL provide: NoOp_i  input  1  ID/EX bubble request from hazard detection.
REQ-007 SHALL provide: Flush_i  input  1  branch taken in ID; squash IF/ID.
REQ-008 SHALL provide: BranchTarget_i  input  32  redirect address.
REQ-009 SHALL provide: Instr_i  input  32  instruction-memory read data at PC_o, same cycle.
REQ-010 SHALL provide: PC_o  output  32  current fetch address.
REQ-011 SHALL provide: IFID_PC_o  output  32  PC of instruction held in IF/ID.
REQ-012 SHALL provide: IFID_Instr_o  output  32  instruction held in IF/ID.
REQ-013 SHALL provide: IFID_Valid_o  output  1  IF/ID holds a real instruction.
REQ-014 SHALL provide: IDEX_Bubble_o  output  1  EX stage currently holds an inserted bubble.
REQ-015 SHALL provide: State_o  output  2  RUN=0, STALL=1, FLUSH=2; 3 never produced.
REQ-016 SHALL provide: StallCnt_o  output  32  stall-cycle count; FlushCnt_o  output  32  flush count.

Function
REQ-017 SHALL gate all PC, IF/ID and counter updates with start_i; start_i=0 holds everything except reset.
REQ-018 SHALL define effective flush as Flush_i & ~Stall_i; stall masks flush (branch operands not yet valid).
REQ-019 PC SHALL load BranchTarget_i on effective flush; else PC_o+4 (mod 2^32, wraps 0xFFFFFFFC->0) when PCWrite_i=1; else hold.
REQ-020 IF/ID SHALL, on effective flush, load Instr=0x00000000, PC=0, Valid=0.
REQ-021 IF/ID SHALL, when Stall_i=1, hold all three fields unchanged.
REQ-022 IF/ID SHALL otherwise load Instr_i, PC_o, Valid=1.
REQ-023 PCWrite_i=0 with Stall_i=0 SHALL hold PC while IF/ID reloads (same-address refetch); no error flagged.
REQ-024 IDEX_Bubble_o SHALL register NoOp_i one cycle after assertion, when start_i=1.
REQ-025 FSM: RUN->STALL on Stall_i; RUN->FLUSH on effective flush; STALL stays while Stall_i; STALL->FLUSH on Flush_i&~Stall_i; STALL->RUN otherwise; FLUSH->STALL on Stall_i, FLUSH->FLUSH on effective flush, else RUN.
REQ-026 Back-to-back stalls of any length SHALL hold IF/ID with no instruction loss or duplication.

Reset
REQ-027 rst_i=1 at a rising edge SHALL set PC_o=0, IFID_PC_o=0, IFID_Instr_o=0, IFID_Valid_o=0, IDEX_Bubble_o=0, State_o=RUN, counters=0.
REQ-028 Reset SHALL override start_i, Stall_i and Flush_i, including mid-stall or mid-flush.

Configuration
REQ-029 With macro PIPE_PERF_CNT_EN defined, StallCnt_o SHALL increment each cycle with start_i&Stall_i, FlushCnt_o each cycle with effective flush; both saturate at 0xFFFFFFFF.
REQ-030 Without PIPE_PERF_CNT_EN, StallCnt_o and FlushCnt_o SHALL be constant 0 with no counter registers.

Verification
REQ-031 Reset, start_i=1, Instr_i=0x00A00093, 3 cycles -> PC_o=0,4,8,12; IFID_Instr_o=0x00A00093, Valid=1 from cycle 1.
REQ-032 At PC_o=8: PCWrite_i=0, Stall_i=1, NoOp_i=1 for 2 cycles -> PC_o holds 8, IF/ID holds PC 4, State_o=1, IDEX_Bubble_o=1 two cycles, StallCnt_o=2.
REQ-033 Flush_i=1, BranchTarget_i=0x40 -> next PC_o=0x40, IFID_Valid_o=0, IFID_Instr_o=0, State_o=2, FlushCnt_o+1.
REQ-034 Flush_i=1 with Stall_i=1 -> no redirect, IF/ID holds, State_o=1; Flush_i held after Stall_i drops -> redirect next cycle.
REQ-035 PC_o=0xFFFFFFFC, PCWrite_i=1 -> PC_o=0; rst_i=1 mid-stall -> all outputs at REQ-027 values next edge.
REQ-036 Without PIPE_PERF_CNT_EN, repeat REQ-032 -> StallCnt_o=0, FlushCnt_o=0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Fetch-side pipeline control for a classic five-stage CPU. Owns the PC and the
// IF/ID pipeline register. Applies the hazard unit's stall, bubble and PC-write
// requests and the branch-flush request from ID. Reports a small RUN/STALL/FLUSH
// status FSM and, optionally, stall/flush performance counters.
//
// Ports
//   clk_i           single clock, all state updates on the rising edge
//   rst_i           synchronous active-high reset
//   start_i         run enable; 0 freezes PC, IF/ID, bubble, FSM and counters
//   PCWrite_i       PC update permit from hazard detection
//   Stall_i         IF/ID hold request from hazard detection
//   NoOp_i          ID/EX bubble request from hazard detection
//   Flush_i         branch taken in ID; squash IF/ID and redirect the PC
//   BranchTarget_i  redirect address
//   Instr_i         instruction-memory read data for PC_o (same cycle)
//   PC_o            current fetch address
//   IFID_PC_o       PC of the instruction held in IF/ID
//   IFID_Instr_o    instruction held in IF/ID
//   IFID_Valid_o    IF/ID holds a real instruction
//   IDEX_Bubble_o   EX stage holds an inserted bubble
//   State_o         RUN=0, STALL=1, FLUSH=2
//   StallCnt_o      stall-cycle count (0 unless PIPE_PERF_CNT_EN)
//   FlushCnt_o      flush count       (0 unless PIPE_PERF_CNT_EN)
//
// Configuration
//   PIPE_PERF_CNT_EN  when defined, builds saturating stall/flush counters;
//                     otherwise both counter outputs are tied to zero.

module pipe_stall_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        PCWrite_i,
    input  logic        Stall_i,
    input  logic        NoOp_i,
    input  logic        Flush_i,
    input  logic [31:0] BranchTarget_i,
    input  logic [31:0] Instr_i,
    output logic [31:0] PC_o,
    output logic [31:0] IFID_PC_o,
    output logic [31:0] IFID_Instr_o,
    output logic        IFID_Valid_o,
    output logic        IDEX_Bubble_o,
    output logic [1:0]  State_o,
    output logic [31:0] StallCnt_o,
    output logic [31:0] FlushCnt_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic        bubble_q, bubble_d;
    state_t      state_q, state_d;
    logic        eff_flush;

    // A stall means the branch operands in ID are not ready yet, so the
    // branch decision cannot be trusted: the stall masks the flush.
    assign eff_flush = Flush_i & ~Stall_i;

    // PC and IF/ID next values. Flush wins over everything else. A stall holds
    // IF/ID. PCWrite_i low without a stall refetches the same address.
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        bubble_d     = bubble_q;
        if (start_i) begin
            bubble_d = NoOp_i;
            if (eff_flush) begin
                pc_d = BranchTarget_i;
            end else if (PCWrite_i) begin
                pc_d = pc_q + 32'd4;
            end
            if (eff_flush) begin
                ifid_pc_d    = 32'd0;
                ifid_instr_d = 32'd0;
                ifid_valid_d = 1'b0;
            end else if (!Stall_i) begin
                ifid_pc_d    = pc_q;
                ifid_instr_d = Instr_i;
                ifid_valid_d = 1'b1;
            end
        end
    end

    // Status FSM. Every state takes the same exits, but the case is kept
    // explicit so each transition is easy to audit.
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            case (state_q)
                ST_RUN, ST_STALL, ST_FLUSH: begin
                    if (Stall_i) begin
                        state_d = ST_STALL;
                    end else if (eff_flush) begin
                        state_d = ST_FLUSH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q         <= 32'd0;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= 32'd0;
            ifid_valid_q <= 1'b0;
            bubble_q     <= 1'b0;
            state_q      <= ST_RUN;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            bubble_q     <= bubble_d;
            state_q      <= state_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: once all-ones they stay there until reset.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (start_i && Stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (start_i && eff_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt_o = stall_cnt_q;
    assign FlushCnt_o = flush_cnt_q;
`else
    assign StallCnt_o = 32'd0;
    assign FlushCnt_o = 32'd0;
`endif

    assign PC_o          = pc_q;
    assign IFID_PC_o     = ifid_pc_q;
    assign IFID_Instr_o  = ifid_instr_q;
    assign IFID_Valid_o  = ifid_valid_q;
    assign IDEX_Bubble_o = bubble_q;
    assign State_o       = state_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
// Self-checking bench for pipe_stall_ctrl. It runs directed scenarios for the
// fetch sequence, stall, flush, stall-masked flush, PC wrap and reset mid-stall.
// It then runs a randomized phase. Both phases are checked against a behavioural
// model of the fetch stage. The model keeps the PC, the IF/ID contents, the last
// bubble request and the counters. The status it expects is derived from what
// the hazard inputs asked for in that cycle.

module tb_pipe_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        PCWrite_i = 1'b0;
    logic        Stall_i = 1'b0;
    logic        NoOp_i = 1'b0;
    logic        Flush_i = 1'b0;
    logic [31:0] BranchTarget_i = 32'd0;
    logic [31:0] Instr_i = 32'd0;
    logic [31:0] PC_o;
    logic [31:0] IFID_PC_o;
    logic [31:0] IFID_Instr_o;
    logic        IFID_Valid_o;
    logic        IDEX_Bubble_o;
    logic [1:0]  State_o;
    logic [31:0] StallCnt_o;
    logic [31:0] FlushCnt_o;

    int checks = 0;
    int failures = 0;

    // Reference model state.
    logic [31:0] m_pc, m_ifid_pc, m_ifid_instr, m_scnt, m_fcnt;
    logic        m_valid, m_bubble;
    logic [1:0]  m_state;

    pipe_stall_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .PCWrite_i(PCWrite_i),
        .Stall_i(Stall_i), .NoOp_i(NoOp_i), .Flush_i(Flush_i),
        .BranchTarget_i(BranchTarget_i), .Instr_i(Instr_i),
        .PC_o(PC_o), .IFID_PC_o(IFID_PC_o), .IFID_Instr_o(IFID_Instr_o),
        .IFID_Valid_o(IFID_Valid_o), .IDEX_Bubble_o(IDEX_Bubble_o),
        .State_o(State_o), .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Instruction memory contents: a distinct word per address.
    function automatic logic [31:0] imem(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic modelStep();
        logic redirect;
        redirect = Flush_i && !Stall_i;
        if (rst_i) begin
            m_pc = 0; m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0;
            m_bubble = 0; m_state = 0; m_scnt = 0; m_fcnt = 0;
        end else if (start_i) begin
            if (redirect) begin
                m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0;
            end else if (!Stall_i) begin
                m_ifid_pc = m_pc; m_ifid_instr = Instr_i; m_valid = 1;
            end
            if (redirect)       m_pc = BranchTarget_i;
            else if (PCWrite_i) m_pc = m_pc + 32'd4;
            m_bubble = NoOp_i;
            m_state = Stall_i ? 2'd1 : (redirect ? 2'd2 : 2'd0);
`ifdef PIPE_PERF_CNT_EN
            if (Stall_i && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
            if (redirect && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
`endif
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_pc"},     PC_o,                  m_pc);
        checkOutput({tag, "_ifpc"},   IFID_PC_o,             m_ifid_pc);
        checkOutput({tag, "_ifins"},  IFID_Instr_o,          m_ifid_instr);
        checkOutput({tag, "_valid"},  {31'd0, IFID_Valid_o}, {31'd0, m_valid});
        checkOutput({tag, "_bubble"}, {31'd0, IDEX_Bubble_o},{31'd0, m_bubble});
        checkOutput({tag, "_state"},  {30'd0, State_o},      {30'd0, m_state});
        checkOutput({tag, "_scnt"},   StallCnt_o,            m_scnt);
        checkOutput({tag, "_fcnt"},   FlushCnt_o,            m_fcnt);
    endtask

    // Drive one cycle of inputs, clock it, then compare everything.
    // The instruction word is what memory returns at the model's current PC.
    task automatic applyStimulus(input logic rst, input logic start, input logic pcw,
                                 input logic stall, input logic noop, input logic flush,
                                 input logic [31:0] bt, input logic fixed_instr,
                                 input string tag);
        rst_i = rst; start_i = start; PCWrite_i = pcw; Stall_i = stall;
        NoOp_i = noop; Flush_i = flush; BranchTarget_i = bt;
        Instr_i = fixed_instr ? 32'h00A0_0093 : imem(m_pc);
        @(posedge clk_i);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    initial begin
        m_pc = 0; m_ifid_pc = 0; m_ifid_instr = 0; m_valid = 0;
        m_bubble = 0; m_state = 0; m_scnt = 0; m_fcnt = 0;
        #2;

        // Reset, then a plain three-cycle fetch of a fixed instruction word.
        applyStimulus(1, 0, 0, 0, 0, 0, 32'd0, 1, "reset");
        checkOutput("reset_pc_zero", PC_o, 32'd0);
        applyStimulus(0, 1, 1, 0, 0, 0, 32'd0, 1, "fetch1");
        checkOutput("fetch1_pc", PC_o, 32'd4);
        checkOutput("fetch1_instr", IFID_Instr_o, 32'h00A0_0093);
        applyStimulus(0, 1, 1, 0, 0, 0, 32'd0, 1, "fetch2");
        checkOutput("fetch2_pc", PC_o, 32'd8);

        // Two-cycle stall with bubbles at PC 8.
        applyStimulus(0, 1, 0, 1, 1, 0, 32'd0, 1, "stall1");
        applyStimulus(0, 1, 0, 1, 1, 0, 32'd0, 1, "stall2");
        checkOutput("stall_pc_hold", PC_o, 32'd8);
        checkOutput("stall_ifpc_hold", IFID_PC_o, 32'd4);
        checkOutput("stall_state", {30'd0, State_o}, 32'd1);
        checkOutput("stall_bubble", {31'd0, IDEX_Bubble_o}, 32'd1);
`ifdef PIPE_PERF_CNT_EN
        checkOutput("stall_cnt", StallCnt_o, 32'd2);
`else
        checkOutput("stall_cnt_off", StallCnt_o, 32'd0);
        checkOutput("flush_cnt_off", FlushCnt_o, 32'd0);
`endif
        applyStimulus(0, 1, 1, 0, 0, 0, 32'd0, 0, "resume");
        checkOutput("resume_ifpc", IFID_PC_o, 32'd8);

        // Taken branch.
        applyStimulus(0, 1, 1, 0, 0, 1, 32'h40, 0, "flush");
        checkOutput("flush_pc", PC_o, 32'h40);
        checkOutput("flush_valid", {31'd0, IFID_Valid_o}, 32'd0);
        checkOutput("flush_state", {30'd0, State_o}, 32'd2);

        // Flush masked by a stall, then honoured once the stall drops.
        applyStimulus(0, 1, 1, 0, 0, 0, 32'd0, 0, "refill");
        applyStimulus(0, 1, 0, 1, 0, 1, 32'h80, 0, "masked");
        checkOutput("masked_pc", PC_o, 32'h44);
        checkOutput("masked_state", {30'd0, State_o}, 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 1, 32'h80, 0, "unmasked");
        checkOutput("unmasked_pc", PC_o, 32'h80);

        // Refetch of the same address when PCWrite is low without a stall.
        applyStimulus(0, 1, 0, 0, 0, 0, 32'd0, 0, "refetch");
        checkOutput("refetch_pc", PC_o, 32'h80);

        // start_i low freezes everything.
        applyStimulus(0, 0, 1, 0, 1, 1, 32'h1234, 0, "frozen");
        checkOutput("frozen_pc", PC_o, 32'h80);

        // PC wrap from the top of the address space.
        applyStimulus(0, 1, 1, 0, 0, 1, 32'hFFFF_FFF8, 0, "wrap_a");
        applyStimulus(0, 1, 1, 0, 0, 0, 32'd0, 0, "wrap_b");
        checkOutput("wrap_top", PC_o, 32'hFFFF_FFFC);
        applyStimulus(0, 1, 1, 0, 0, 0, 32'd0, 0, "wrap_c");
        checkOutput("wrap_zero", PC_o, 32'd0);

        // Reset in the middle of a stall, with every other request asserted.
        applyStimulus(0, 1, 0, 1, 1, 0, 32'd0, 0, "prerst");
        applyStimulus(1, 1, 1, 1, 1, 1, 32'h55, 0, "midrst");
        checkOutput("midrst_state", {30'd0, State_o}, 32'd0);
        checkOutput("midrst_bubble", {31'd0, IDEX_Bubble_o}, 32'd0);

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 59) == 0),
                          ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 3) == 0),
                          $urandom_range(0, 1),
                          ($urandom_range(0, 4) == 0),
                          ($urandom & 32'hFFFF_FFFC), 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
